fm_demod_qarctan: RTL and testbench
===================================

Name: fm_demod_qarctan

Overview:
- FM discriminator stage that sits directly upstream of the 32-bit iterative signed divider and consumes its result.
- Per accepted I/Q sample, forms the conjugate product with the previous sample and builds the quantized arctan ratio operands.
- Issues one divide request, waits for the quotient, finishes the quadrant-corrected angle, applies demod gain, and emits one audio sample.

Parameters:
DATA_WIDTH, 32, width of I/Q inputs, divider operands and output sample (two's complement)
BITS, 10, quantization shift; QUANT(v)=v<<<BITS, DEQUANT(v)=v/2^BITS truncated toward zero
QUAD1, 804, QUANT(pi/4)
QUAD3, 2412, 3*QUAD1
GAIN, 758, demod gain in QUANT units

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  I/Q sample valid
in_ready  out  1  block can accept a sample
in_real  in  DATA_WIDTH  signed I sample
in_imag  in  DATA_WIDTH  signed Q sample
div_valid_in  out  1  one-cycle divide request to divider
div_dividend  out  DATA_WIDTH  signed dividend to divider
div_divisor  out  DATA_WIDTH  signed divisor to divider
div_quotient  in  DATA_WIDTH  signed quotient from divider
div_valid_out  in  1  divider result valid (single-cycle pulse)
div_overflow  in  1  divider divide-by-zero flag
out_valid  out  1  demodulated sample valid
out_ready  in  1  downstream accepts sample
out_data  out  DATA_WIDTH  demodulated sample

Behaviour:
- Clock and reset: clk; reset is asynchronous, active-high.
- Reset values: all registers 0; state IDLE; in_ready=1, div_valid_in=0, out_valid=0, out_data=0, div_dividend=0, div_divisor=1; prev_real=prev_imag=0.
- Arithmetic:
  - Products computed at 2*DATA_WIDTH and truncated to DATA_WIDTH LSBs (C int wrap semantics).
  - QUANT is a left shift with wrap.
  - DEQUANT is signed division by 2^BITS, truncating toward zero (not an arithmetic shift).
- States:
  - IDLE: in_ready=1. On in_valid: latch cur=(in_real,in_imag); x=DEQUANT(prev_r*cur_r)+DEQUANT(prev_i*cur_i); y=DEQUANT(prev_r*cur_i)-DEQUANT(prev_i*cur_r); prev<=cur; go PREP. in_ready=0 in all other states.
  - PREP: abs_y=|y|+1.
    - x>=0: dividend=QUANT(x-abs_y), divisor=x+abs_y, base=QUAD1.
    - x<0: dividend=QUANT(x+abs_y), divisor=abs_y-x, base=QUAD3.
    - Register operands and record sign(y). Go REQ.
  - REQ: div_valid_in=1 for exactly one cycle; go WAIT.
  - WAIT: hold div_dividend/div_divisor stable (the divider re-reads them until its result pulse). On div_valid_out: q=div_quotient; go ANGLE. div_valid_out in any other state is ignored.
  - ANGLE: angle=base-DEQUANT(QUAD1*q); negate if y<0. If div_overflow was high with the result, angle=0. Go GAIN.
  - GAIN: out_data<=DEQUANT(GAIN*angle); go OUT.
  - OUT: out_valid=1, out_data stable until out_ready. On out_valid&&out_ready go IDLE (next sample accepted no earlier than the following cycle).
- Latency: 5 cycles plus divider latency from input accept to out_valid. No pipelining; one sample in flight.
- Divisor is never 0 by construction (abs_y>=1); overflow handling is defensive only.
- Reset mid-operation: abandon sample, clear prev, drop div_valid_in immediately. A divider result arriving after reset is ignored.

Optional Feature:
- Macro: FM_DEMOD_GAIN_EN.
- Defined: GAIN state present; out_data=DEQUANT(GAIN*angle).
- Undefined: GAIN state removed; ANGLE goes straight to OUT with out_data=angle; latency one cycle less.

Test Plan:
(All values with FM_DEMOD_GAIN_EN defined.)
- After reset, first sample (1024,0) -> dividend=-1024, divisor=1, quotient -1024, angle 1608, out_data=1190.
- Then (1024,0) -> dividend=1047552, divisor=1025, quotient 1022, angle 2, out_data=1.
- Then (0,-1024) after prev=(1024,0) -> x=0, y=-1024, dividend=-1049600, divisor=1025, angle -1608, out_data=-1190 (truncation toward zero).
- Then (-1024,0) after prev=(1024,0) -> dividend=-1047552, divisor=1025, quotient -1022, angle 3214, out_data=2379.
- Hold out_ready=0 for 10 cycles with in_valid=1 -> out_valid/out_data stable, in_ready=0, no new div_valid_in. Release -> exactly one handshake, then next sample accepted.
- Assert reset during WAIT, then inject div_valid_out -> ignored, no out_valid. Next sample (1024,0) yields out_data=1190 (prev cleared).

Source files
------------

// File: rtl/fm_demod_qarctan.sv
// fm_demod_qarctan: FM discriminator built on a quantized arctan approximation
// that drives an external iterative divider. Define FM_DEMOD_GAIN_EN for the gain stage.
`timescale 1ns/1ps
module fm_demod_qarctan #(
    parameter int DATA_WIDTH = 32,
    parameter int BITS       = 10,
    parameter int QUAD1      = 804,
`ifdef FM_DEMOD_GAIN_EN
    parameter int GAIN       = 758,
`endif
    parameter int QUAD3      = 2412
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_real,
    input  logic [DATA_WIDTH-1:0] in_imag,
    output logic                  div_valid_in,
    output logic [DATA_WIDTH-1:0] div_dividend,
    output logic [DATA_WIDTH-1:0] div_divisor,
    input  logic [DATA_WIDTH-1:0] div_quotient,
    input  logic                  div_valid_out,
    input  logic                  div_overflow,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int W = DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_REQ   = 3'd2,
        S_WAIT  = 3'd3,
        S_ANGLE = 3'd4,
`ifdef FM_DEMOD_GAIN_EN
        S_GAIN  = 3'd5,
`endif
        S_OUT   = 3'd6
    } state_t;

    state_t state;

    logic signed [W-1:0] prev_real;
    logic signed [W-1:0] prev_imag;
    logic signed [W-1:0] x_r;
    logic signed [W-1:0] y_r;
    logic signed [W-1:0] base_r;
    logic signed [W-1:0] q_r;
    logic                y_neg;
    logic                ovf_r;
`ifdef FM_DEMOD_GAIN_EN
    logic signed [W-1:0] angle_r;
`endif

    logic signed [W-1:0] cur_real;
    logic signed [W-1:0] cur_imag;
    logic signed [W-1:0] x_nxt;
    logic signed [W-1:0] y_nxt;
    logic signed [W-1:0] abs_y;
    logic signed [W-1:0] prep_dividend;
    logic signed [W-1:0] prep_divisor;
    logic signed [W-1:0] prep_base;
    logic signed [W-1:0] angle_nxt;

    // Low W bits of the full-width signed product (C int wrap).
    function automatic logic signed [W-1:0] mul_lo(
        input logic signed [W-1:0] a,
        input logic signed [W-1:0] b
    );
        logic signed [2*W-1:0] p;
        p = (2*W)'(a) * (2*W)'(b);
        return p[W-1:0];
    endfunction

    // Divide by 2^BITS rounding toward zero: bias negatives before shifting.
    function automatic logic signed [W-1:0] dequant(
        input logic signed [W-1:0] v
    );
        logic signed [W-1:0] bias;
        bias = v[W-1] ? W'((1 << BITS) - 1) : '0;
        return (v + bias) >>> BITS;
    endfunction

    assign cur_real = in_real;
    assign cur_imag = in_imag;

    // Conjugate product, arctan ratio operands and final angle.
    always_comb begin
        x_nxt = dequant(mul_lo(prev_real, cur_real))
              + dequant(mul_lo(prev_imag, cur_imag));
        y_nxt = dequant(mul_lo(prev_real, cur_imag))
              - dequant(mul_lo(prev_imag, cur_real));
        abs_y = (y_r[W-1] ? -y_r : y_r) + W'(1);
        if (!x_r[W-1]) begin
            prep_dividend = (x_r - abs_y) <<< BITS;
            prep_divisor  = x_r + abs_y;
            prep_base     = W'(QUAD1);
        end else begin
            prep_dividend = (x_r + abs_y) <<< BITS;
            prep_divisor  = abs_y - x_r;
            prep_base     = W'(QUAD3);
        end
        angle_nxt = base_r - dequant(mul_lo(W'(QUAD1), q_r));
        if (y_neg) begin
            angle_nxt = -angle_nxt;
        end
        if (ovf_r) begin
            angle_nxt = '0;
        end
    end

    // Sequencer: one sample in flight from accept to output handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            in_ready     <= 1'b1;
            div_valid_in <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= W'(1);
            out_valid    <= 1'b0;
            out_data     <= '0;
            prev_real    <= '0;
            prev_imag    <= '0;
            x_r          <= '0;
            y_r          <= '0;
            base_r       <= '0;
            q_r          <= '0;
            y_neg        <= 1'b0;
            ovf_r        <= 1'b0;
`ifdef FM_DEMOD_GAIN_EN
            angle_r      <= '0;
`endif
        end else begin
            div_valid_in <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x_r       <= x_nxt;
                        y_r       <= y_nxt;
                        prev_real <= cur_real;
                        prev_imag <= cur_imag;
                        in_ready  <= 1'b0;
                        state     <= S_PREP;
                    end
                end
                S_PREP: begin
                    div_dividend <= prep_dividend;
                    div_divisor  <= prep_divisor;
                    base_r       <= prep_base;
                    y_neg        <= y_r[W-1];
                    div_valid_in <= 1'b1;
                    state        <= S_REQ;
                end
                S_REQ: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (div_valid_out) begin
                        q_r   <= div_quotient;
                        ovf_r <= div_overflow;
                        state <= S_ANGLE;
                    end
                end
                S_ANGLE: begin
`ifdef FM_DEMOD_GAIN_EN
                    angle_r   <= angle_nxt;
                    state     <= S_GAIN;
`else
                    out_data  <= angle_nxt;
                    out_valid <= 1'b1;
                    state     <= S_OUT;
`endif
                end
`ifdef FM_DEMOD_GAIN_EN
                S_GAIN: begin
                    out_data  <= dequant(mul_lo(W'(GAIN), angle_r));
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end
`endif
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fm_demod_qarctan.sv
// tb_fm_demod_qarctan: directed test of the FM discriminator with a
// behavioural divider that answers with hand-computed quotients.
`timescale 1ns/1ps
module tb_fm_demod_qarctan;

`ifdef FM_DEMOD_GAIN_EN
    localparam int O1 = 1190;
    localparam int O2 = 1;
    localparam int O3 = -1190;
    localparam int O5 = 2379;
`else
    localparam int O1 = 1608;
    localparam int O2 = 2;
    localparam int O3 = -1608;
    localparam int O5 = 3214;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_real = '0;
    logic [31:0] in_imag = '0;
    logic        div_valid_in;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [31:0] div_quotient = '0;
    logic        div_valid_out = 1'b0;
    logic        div_overflow = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;

    int n_checks = 0;
    int n_fail = 0;

    fm_demod_qarctan dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_real      (in_real),
        .in_imag      (in_imag),
        .div_valid_in (div_valid_in),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_quotient (div_quotient),
        .div_valid_out(div_valid_out),
        .div_overflow (div_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d",
                   tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic send(input int r, input int i);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_real  = r;
        in_imag  = i;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic div_req(input int exp_dd, input int exp_ds);
        int n;
        n = 0;
        while (div_valid_in !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("div_req_seen", 32'(div_valid_in), 32'd1);
        check("dividend", div_dividend, exp_dd);
        check("divisor", div_divisor, exp_ds);
        @(negedge clk);
        check("div_req_pulse", 32'(div_valid_in), 32'd0);
        repeat (3) @(negedge clk);
        check("dividend_hold", div_dividend, exp_dd);
        check("divisor_hold", div_divisor, exp_ds);
    endtask

    task automatic div_resp(input int q, input logic ovf);
        div_quotient  = q;
        div_overflow  = ovf;
        div_valid_out = 1'b1;
        @(negedge clk);
        div_valid_out = 1'b0;
        div_overflow  = 1'b0;
        div_quotient  = 32'hdead_beef;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_seen", 32'(out_valid), 32'd1);
    endtask

    task automatic get_out(input int exp);
        wait_out();
        check("out_data", out_data, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", 32'(out_valid), 32'd0);
    endtask

    initial begin
        bit saw;

        // reset values
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_div_valid", 32'(div_valid_in), 32'd0);
        check("rst_dividend", div_dividend, 32'd0);
        check("rst_divisor", div_divisor, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // first sample after reset, prev = 0
        send(1024, 0);
        div_req(-1024, 1);
        div_resp(-1024, 1'b0);
        get_out(O1);

        // same phase again, then hold the output with a sample waiting
        send(1024, 0);
        div_req(1047552, 1025);
        div_resp(1022, 1'b0);
        wait_out();
        check("s2_out_data", out_data, O2);
        in_real  = 0;
        in_imag  = -1024;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_out_data", out_data, O2);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_div_valid", 32'(div_valid_in), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("rel_out_valid", 32'(out_valid), 32'd0);
        check("rel_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("rel_accepted", 32'(in_ready), 32'd0);
        check("rel_one_hs", 32'(out_valid), 32'd0);

        // (0,-1024) after (1024,0): negative y, truncation toward zero
        div_req(-1049600, 1025);
        div_resp(-1024, 1'b0);
        get_out(O3);

        // (1024,0) after (0,-1024): positive y
        send(1024, 0);
        div_req(-1049600, 1025);
        div_resp(-1024, 1'b0);
        get_out(O1);

        // (-1024,0) after (1024,0): left half plane
        send(-1024, 0);
        div_req(-1047552, 1025);
        div_resp(-1022, 1'b0);
        get_out(O5);

        // reset while waiting on the divider
        send(1024, 0);
        div_req(-1047552, 1025);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_div_valid", 32'(div_valid_in), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_divisor", div_divisor, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        div_resp(-1024, 1'b0);
        saw = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || div_valid_in !== 1'b0) saw = 1'b1;
        end
        check("late_result_ignored", 32'(saw), 32'd0);

        // prev cleared by reset
        send(1024, 0);
        div_req(-1024, 1);
        div_resp(-1024, 1'b0);
        get_out(O1);

        // divider overflow forces a zero angle
        send(1024, 0);
        div_req(1047552, 1025);
        div_resp(12345, 1'b1);
        get_out(0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
